sa: RTL and testbench

Switch allocator for the 4-port packet switch: per output port, it arbitrates among the four input buffers' head-of-queue flits and holds the winning input until its tail flit has passed. Packets move wormhole-style.
- It drives the per-output one-hot grant vectors (`ack0..ack3`) that steer the crossbar.
- It drives per-input dequeue strobes back to the input buffers.
- It sits between the input buffers and the crossbar: same clock as both, no datapath of its own.

---
 rtl/sa_if.sv | 16 +
 rtl/sa.sv | 94 +++++++++
 tb/tb_sa.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sa_if.sv
// sa_if: input-buffer/crossbar side signals of the switch allocator, grouped per port
interface sa_if;
   logic [9:0] co0, co1, co2, co3;
   logic       rdy0, rdy1, rdy2, rdy3;
   logic [3:0] ack0, ack1, ack2, ack3;
   logic       deq0, deq1, deq2, deq3;
   logic       busy0, busy1, busy2, busy3;
   modport master (
      output co0, co1, co2, co3, rdy0, rdy1, rdy2, rdy3,
      input  ack0, ack1, ack2, ack3, deq0, deq1, deq2, deq3, busy0, busy1, busy2, busy3
   );
   modport slave (
      input  co0, co1, co2, co3, rdy0, rdy1, rdy2, rdy3,
      output ack0, ack1, ack2, ack3, deq0, deq1, deq2, deq3, busy0, busy1, busy2, busy3
   );
endinterface

// File: rtl/sa.sv
// sa: wormhole switch allocator, per-output round-robin grant held until the tail flit passes
module sa (
   input logic clk,
   input logic rst,
   sa_if.slave s
);
   typedef enum logic {IDLE, BUSY} st_t;
   st_t        st [4];
   st_t        st_nx [4];
   logic [1:0] own [4];
   logic [1:0] own_nx [4];
   logic [1:0] ptr [4];
   logic [1:0] ptr_nx [4];
   logic [1:0] typ [4];
   logic [1:0] dst [4];
   logic [3:0] rdy;
   logic [3:0] ack [4];
   logic [3:0] owned;
   logic       found;
   logic [1:0] win;
   logic [1:0] idx;
   assign typ[0] = s.co0[9:8];
   assign typ[1] = s.co1[9:8];
   assign typ[2] = s.co2[9:8];
   assign typ[3] = s.co3[9:8];
   assign dst[0] = s.co0[1:0];
   assign dst[1] = s.co1[1:0];
   assign dst[2] = s.co2[1:0];
   assign dst[3] = s.co3[1:0];
   assign rdy = {s.rdy3, s.rdy2, s.rdy1, s.rdy0};
   assign s.ack0 = ack[0];
   assign s.ack1 = ack[1];
   assign s.ack2 = ack[2];
   assign s.ack3 = ack[3];
   assign s.deq0 = ack[0][0] | ack[1][0] | ack[2][0] | ack[3][0];
   assign s.deq1 = ack[0][1] | ack[1][1] | ack[2][1] | ack[3][1];
   assign s.deq2 = ack[0][2] | ack[1][2] | ack[2][2] | ack[3][2];
   assign s.deq3 = ack[0][3] | ack[1][3] | ack[2][3] | ack[3][3];
   assign s.busy0 = st[0] == BUSY;
   assign s.busy1 = st[1] == BUSY;
   assign s.busy2 = st[2] == BUSY;
   assign s.busy3 = st[3] == BUSY;
   // Mealy grant: round-robin among unowned heads when idle, otherwise follow the owner until its tail
   always_comb begin
      owned = '0;
      found = 1'b0;
      win = '0;
      idx = '0;
      for (int n = 0; n < 4; n++) if (st[n] == BUSY) owned[own[n]] = 1'b1;
      for (int n = 0; n < 4; n++) begin
         ack[n] = '0;
         st_nx[n] = st[n];
         own_nx[n] = own[n];
         ptr_nx[n] = ptr[n];
         found = 1'b0;
         win = ptr[n];
         for (int k = 0; k < 4; k++) begin
            idx = ptr[n] + 2'(k);
            if (!found && !owned[idx] && typ[idx] == 2'b01 && dst[idx] == 2'(n)) begin
               found = 1'b1;
               win = idx;
            end
         end
         if (st[n] == IDLE) begin
            if (rdy[n] && found) begin
               ack[n][win] = 1'b1;
               st_nx[n] = BUSY;
               own_nx[n] = win;
               ptr_nx[n] = win + 2'd1;
            end
         end else if (rdy[n] && typ[own[n]][1]) begin
            ack[n][own[n]] = 1'b1;
            st_nx[n] = typ[own[n]][0] ? IDLE : BUSY;
         end
         if (rst) ack[n] = '0;
      end
   end
   // Per-output FSM, owner and round-robin pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < 4; n++) begin
            st[n] <= IDLE;
            own[n] <= '0;
            ptr[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            st[n] <= st_nx[n];
            own[n] <= own_nx[n];
            ptr[n] <= ptr_nx[n];
         end
      end
   end
endmodule

// File: tb/tb_sa.sv
// tb_sa: directed self-checking bench for the switch allocator
module tb_sa;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vec = 0;
   int err = 0;
   logic [3:0] deq;
   logic [9:0] bdy = 10'h2a5;
   logic [9:0] tl = 10'h35a;
   sa_if bus ();
   sa dut (.clk(clk), .rst(rst), .s(bus.slave));
   always #5 clk = ~clk;
   assign deq = {bus.deq3, bus.deq2, bus.deq1, bus.deq0};

   function automatic logic [9:0] hd(input int d);
      return {2'b01, 6'b010101, 2'(d)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_co(input int i, input logic [9:0] v);
      case (i)
         0: bus.co0 = v;
         1: bus.co1 = v;
         2: bus.co2 = v;
         default: bus.co3 = v;
      endcase
   endtask

   task automatic clr();
      bus.co0 = '0; bus.co1 = '0; bus.co2 = '0; bus.co3 = '0;
      bus.rdy0 = 1'b0; bus.rdy1 = 1'b0; bus.rdy2 = 1'b0; bus.rdy3 = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clr();
      #2;
      vec++; if ({bus.ack3, bus.ack2, bus.ack1, bus.ack0} !== 16'h0) begin err++; $display("FAIL reset_ack got %h want 0000", {bus.ack3, bus.ack2, bus.ack1, bus.ack0}); end
      vec++; if ({bus.busy3, bus.busy2, bus.busy1, bus.busy0} !== 4'b0) begin err++; $display("FAIL reset_busy got %b want 0000", {bus.busy3, bus.busy2, bus.busy1, bus.busy0}); end
      tick();
      rst = 1'b0;
      bus.co0 = hd(0); bus.rdy0 = 1'b1;
      #2;
      vec++; if (bus.ack0 !== 4'b0001) begin err++; $display("FAIL reset_pre_head got %b want 0001", bus.ack0); end
      tick();
      bus.co0 = bdy;
      #1;
      vec++; if (bus.busy0 !== 1'b1) begin err++; $display("FAIL reset_pre_busy got %b want 1", bus.busy0); end
      rst = 1'b1;
      #1;
      vec++; if (bus.ack0 !== 4'b0000) begin err++; $display("FAIL reset_mid_ack got %b want 0000", bus.ack0); end
      vec++; if (bus.deq0 !== 1'b0) begin err++; $display("FAIL reset_mid_deq got %b want 0", bus.deq0); end
      vec++; if (bus.busy0 !== 1'b0) begin err++; $display("FAIL reset_mid_busy got %b want 0", bus.busy0); end
      tick();
      rst = 1'b0;
      bus.co0 = 10'b01_0000_0000;
      #2;
      vec++; if (bus.ack0 !== 4'b0001) begin err++; $display("FAIL reset_after_head got %b want 0001", bus.ack0); end
      vec++; if (bus.deq0 !== 1'b1) begin err++; $display("FAIL reset_after_deq got %b want 1", bus.deq0); end
   endtask

   task automatic test_single();
      logic [9:0] pk [4];
      do_reset();
      pk[0] = hd(2); pk[1] = bdy; pk[2] = 10'h2ff; pk[3] = tl;
      bus.rdy2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.co1 = pk[c];
         #2;
         vec++; if (bus.ack2 !== 4'b0010) begin err++; $display("FAIL single_ack2 c%0d got %b want 0010", c, bus.ack2); end
         vec++; if (deq !== 4'b0010) begin err++; $display("FAIL single_deq c%0d got %b want 0010", c, deq); end
         vec++; if (bus.busy2 !== (c != 0)) begin err++; $display("FAIL single_busy2 c%0d got %b want %b", c, bus.busy2, c != 0); end
         tick();
      end
      bus.co1 = '0;
      #2;
      vec++; if (bus.busy2 !== 1'b0) begin err++; $display("FAIL single_busy2_end got %b want 0", bus.busy2); end
      vec++; if (bus.ack2 !== 4'b0000) begin err++; $display("FAIL single_ack2_end got %b want 0000", bus.ack2); end
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.rdy3 = 1'b1;
      for (int w = 0; w < 4; w++) begin
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) set_co(i, i < w ? 10'h0 : (i == w && p == 1) ? tl : hd(3));
            #2;
            vec++; if (bus.ack3 !== 4'(1 << w)) begin err++; $display("FAIL rr_ack3 w%0d p%0d got %b want %b", w, p, bus.ack3, 4'(1 << w)); end
            vec++; if (deq !== 4'(1 << w)) begin err++; $display("FAIL rr_deq w%0d p%0d got %b want %b", w, p, deq, 4'(1 << w)); end
            vec++; if (bus.busy3 !== (p == 1)) begin err++; $display("FAIL rr_busy3 w%0d p%0d got %b want %b", w, p, bus.busy3, p == 1); end
            tick();
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.rdy0 = 1'b1;
      bus.co2 = hd(0);
      #2;
      vec++; if (bus.ack0 !== 4'b0100) begin err++; $display("FAIL wrap_pre_head got %b want 0100", bus.ack0); end
      tick();
      bus.co2 = tl;
      tick();
      bus.co2 = '0; bus.co0 = hd(0); bus.co3 = hd(0);
      #2;
      vec++; if (bus.ack0 !== 4'b1000) begin err++; $display("FAIL wrap_first got %b want 1000", bus.ack0); end
      tick();
      bus.co3 = tl;
      #2;
      vec++; if (bus.ack0 !== 4'b1000) begin err++; $display("FAIL wrap_tail3 got %b want 1000", bus.ack0); end
      vec++; if (deq !== 4'b1000) begin err++; $display("FAIL wrap_stall0 got %b want 1000", deq); end
      tick();
      bus.co3 = '0;
      #2;
      vec++; if (bus.ack0 !== 4'b0001) begin err++; $display("FAIL wrap_second got %b want 0001", bus.ack0); end
      tick();
      bus.co0 = tl;
      #2;
      vec++; if (bus.ack0 !== 4'b0001) begin err++; $display("FAIL wrap_tail0 got %b want 0001", bus.ack0); end
      tick();
   endtask

   task automatic test_parallel();
      logic [9:0] c0 [6];
      logic [9:0] c2 [6];
      logic       r3 [6];
      logic [3:0] e1 [6];
      logic [3:0] e3 [6];
      do_reset();
      c0 = '{hd(1), bdy, bdy, bdy, tl, 10'h0};
      c2 = '{hd(3), bdy, bdy, bdy, bdy, tl};
      r3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      e1 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
      e3 = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
      bus.rdy1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bus.co0 = c0[c]; bus.co2 = c2[c]; bus.rdy3 = r3[c];
         #2;
         vec++; if (bus.ack1 !== e1[c]) begin err++; $display("FAIL par_ack1 c%0d got %b want %b", c, bus.ack1, e1[c]); end
         vec++; if (bus.ack3 !== e3[c]) begin err++; $display("FAIL par_ack3 c%0d got %b want %b", c, bus.ack3, e3[c]); end
         vec++; if (bus.deq2 !== e3[c][2]) begin err++; $display("FAIL par_deq2 c%0d got %b want %b", c, bus.deq2, e3[c][2]); end
         vec++; if (bus.busy3 !== (c != 0)) begin err++; $display("FAIL par_busy3 c%0d got %b want %b", c, bus.busy3, c != 0); end
         tick();
      end
      clr();
      #2;
      vec++; if (bus.busy3 !== 1'b0) begin err++; $display("FAIL par_busy3_end got %b want 0", bus.busy3); end
   endtask

   task automatic test_protocol();
      do_reset();
      bus.rdy0 = 1'b1; bus.rdy1 = 1'b1; bus.rdy2 = 1'b1; bus.rdy3 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         bus.co3 = c[0] ? tl : bdy;
         #2;
         vec++; if ({bus.ack3[3], bus.ack2[3], bus.ack1[3], bus.ack0[3]} !== 4'b0000) begin err++; $display("FAIL proto_orphan_ack c%0d got %b want 0000", c, {bus.ack3[3], bus.ack2[3], bus.ack1[3], bus.ack0[3]}); end
         vec++; if (bus.deq3 !== 1'b0) begin err++; $display("FAIL proto_orphan_deq c%0d got %b want 0", c, bus.deq3); end
         tick();
      end
      bus.co3 = '0;
      bus.co0 = hd(1);
      #2;
      vec++; if (bus.ack1 !== 4'b0001) begin err++; $display("FAIL proto_head got %b want 0001", bus.ack1); end
      tick();
      #2;
      vec++; if (bus.ack1 !== 4'b0000) begin err++; $display("FAIL proto_head_busy got %b want 0000", bus.ack1); end
      vec++; if (bus.busy1 !== 1'b1) begin err++; $display("FAIL proto_busy1 got %b want 1", bus.busy1); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_parallel();
      test_protocol();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
